// File: rtl/lamp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lamp_pkg
//  Purpose  : Lamp codes and monitor state encoding shared by the cyclic lamp
//             controller and lamp_monitor, plus small decode helpers.
//  Contents : RED / GREEN / YELLOW one-hot codes, lamp_state_t (IDLE/TRACK),
//             is_lamp_code(), next_colour().
//  Revision : 1.0 - initial release
// ============================================================================
package lamp_pkg;

   // One-hot lamp codes, written MSB first as they appear on the light bus.
   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] GREEN  = 3'b010;
   localparam logic [2:0] YELLOW = 3'b001;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      TRACK = 1'b1
   } lamp_state_t;

   // True when the code is exactly one of the three lamp colours.
   function automatic logic is_lamp_code(input logic [2:0] code);
      return (code == RED) || (code == GREEN) || (code == YELLOW);
   endfunction

   // Colour the controller is allowed to step to from a legal colour.
   function automatic logic [2:0] next_colour(input logic [2:0] code);
      case (code)
         RED:     return GREEN;
         GREEN:   return YELLOW;
         default: return RED;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter that sticks at its all-ones value.
//  Ports    : clock  - rising-edge clock
//             reset  - synchronous active-high clear
//             inc    - count by one this cycle
//             count  - registered count, saturating at 2**WIDTH-1
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != COUNT_MAX)) begin
         count <= count + COUNT_ONE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/lamp_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : lamp_monitor
//  Purpose  : Watches the lamp code from a cyclic traffic-lamp controller and
//             flags illegal codes, out-of-order colour changes and colours
//             held longer than MAX_DWELL samples. Counts completed cycles and
//             error cycles; keeps a sticky fault flag.
//  Ports    : clock       - rising-edge clock
//             reset       - synchronous active-high reset
//             light[0:2]  - lamp code (RED=100, GREEN=010, YELLOW=001)
//             clear_err   - clears the sticky fault flag
//             in_sync     - high while tracking a legal sequence
//             err_onehot  - pulse: sample is not a lamp code
//             err_order   - pulse: illegal colour transition
//             err_stuck   - pulse: colour held beyond MAX_DWELL samples
//             fault       - sticky OR of the error pulses
//             cycle_count - completed R-G-Y cycles, wraps at 256
//             err_count   - cycles with any error, saturates at 255
//  Revision : 1.0 - initial release
// ============================================================================
module lamp_monitor
   import lamp_pkg::*;
#(
   parameter int MAX_DWELL = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [0:2] light,
   input  logic       clear_err,
   output logic       in_sync,
   output logic       err_onehot,
   output logic       err_order,
   output logic       err_stuck,
   output logic       fault,
   output logic [7:0] cycle_count,
   output logic [7:0] err_count
);

   // Smallest width that can hold MAX_DWELL itself.
   localparam int                 DWELL_W   = $clog2(MAX_DWELL + 1);
   localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(MAX_DWELL);
   localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

   lamp_state_t        r_state;
   logic [2:0]         r_prev;
   logic [DWELL_W-1:0] r_dwell;

   logic w_legal;
   logic w_same;
   logic w_succ;
   logic w_err_onehot;
   logic w_err_order;
   logic w_err_stuck;
   logic w_any_err;

   // Classify the current sample against the tracked colour.
   always_comb begin
      w_legal      = is_lamp_code(light);
      w_same       = (light == r_prev);
      w_succ       = (light == next_colour(r_prev));
      w_err_onehot = !w_legal;
      w_err_order  = (r_state == TRACK) && w_legal && !w_same && !w_succ;
      w_err_stuck  = (r_state == TRACK) && w_legal && w_same && (r_dwell == DWELL_MAX);
      w_any_err    = w_err_onehot || w_err_order || w_err_stuck;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_prev      <= '0;
         r_dwell     <= '0;
         in_sync     <= 1'b0;
         err_onehot  <= 1'b0;
         err_order   <= 1'b0;
         err_stuck   <= 1'b0;
         fault       <= 1'b0;
         cycle_count <= '0;
      end else begin
         err_onehot <= w_err_onehot;
         err_order  <= w_err_order;
         err_stuck  <= w_err_stuck;
         // A new error wins over a simultaneous clear.
         fault      <= (fault && !clear_err) || w_any_err;

         case (r_state)
            IDLE: begin
               // First legal sample is accepted without an order check.
               if (w_legal) begin
                  r_prev  <= light;
                  r_dwell <= DWELL_ONE;
                  r_state <= TRACK;
                  in_sync <= 1'b1;
               end
            end

            TRACK: begin
               if (!w_legal) begin
                  r_dwell <= '0;
                  r_state <= IDLE;
                  in_sync <= 1'b0;
               end else if (w_same) begin
                  // On a dwell violation restart the run at one sample.
                  r_dwell <= w_err_stuck ? DWELL_ONE : r_dwell + DWELL_ONE;
               end else begin
                  // Legal step or order error: resynchronise on the new colour.
                  r_prev  <= light;
                  r_dwell <= DWELL_ONE;
                  if (w_succ && (r_prev == YELLOW)) begin
                     cycle_count <= cycle_count + 8'd1;
                  end
               end
            end

            default: begin
               r_state <= IDLE;
               in_sync <= 1'b0;
            end
         endcase
      end
   end

   sat_counter #(
      .WIDTH (8)
   ) u_err_count (
      .clock (clock),
      .reset (reset),
      .inc   (w_any_err),
      .count (err_count)
   );

endmodule
`default_nettype wire
